// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, ALU/state enums and instruction field helpers for the sb execute stage
package cpu_pkg;

    localparam logic [7:0] OP_ARITH = 8'h01;
    localparam logic [7:0] OP_LD    = 8'h02;
    localparam logic [7:0] OP_ST    = 8'h03;
    localparam logic [7:0] OP_BR    = 8'h04;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_WB       = 3'd4
    } exec_state_e;

    function automatic logic [4:0] get_dest(input logic [31:0] insn);
        return insn[11:7];
    endfunction

    function automatic alu_op_e get_aop(input logic [31:0] insn);
        return alu_op_e'(insn[14:12]);
    endfunction

    function automatic logic [31:0] get_imm(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

endpackage

// File: rtl/sb_alu.sv
// rtl/sb_alu.sv - combinational ALU for the sb execute stage
module sb_alu
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         aop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic lt;
    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (aop)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/sb_exec_stage.sv
// rtl/sb_exec_stage.sv - non-branch execute/writeback stage; SB_EXEC_PERF_CNT_EN adds perf counters
module sb_exec_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OPW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_insn,
    input  logic [OPW-1:0]    in_opcode,
    input  logic [XLEN-1:0]   in_arg1,
    input  logic [XLEN-1:0]   in_arg2,
    output logic              spawn_valid,
    input  logic              spawn_ready,
    output logic [XLEN-1:0]   spawn_pc,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_data,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_write_addr,
    output logic [XLEN-1:0]   rf_write_val,
    output logic              illegal_op
`ifdef SB_EXEC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_arith,
    output logic [31:0]       perf_mem,
    output logic [31:0]       perf_illegal
`endif
);

    exec_state_e state_q, state_d;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     insn_q;
    logic [OPW-1:0]  op_q;
    logic [XLEN-1:0] arg1_q;
    logic [XLEN-1:0] arg2_q;
    logic [XLEN-1:0] result_q;
    logic            spawn_pend_q;
    logic            illegal_q;

    logic            accept;
    logic            in_is_arith;
    logic            in_is_mem;
    logic            is_ld_q;
    logic            is_st_q;
    logic            mem_fire;
    logic [XLEN-1:0] imm_x;
    logic [REG_AW-1:0] dest_q;
    logic [XLEN-1:0] alu_res;
    logic            unused_insn_bits;

    assign accept      = in_valid && in_ready;
    assign in_is_arith = (in_opcode == OPW'(OP_ARITH));
    assign in_is_mem   = (in_opcode == OPW'(OP_LD)) || (in_opcode == OPW'(OP_ST));
    assign is_ld_q     = (op_q == OPW'(OP_LD));
    assign is_st_q     = (op_q == OPW'(OP_ST));
    assign mem_fire    = (state_q == ST_MEM_REQ) && dmem_req_ready;
    assign imm_x       = XLEN'(get_imm(insn_q));
    assign dest_q      = REG_AW'(get_dest(insn_q));
    assign unused_insn_bits = ^{insn_q[19:15], insn_q[6:0]};

    // The spawn only depends on the registered pc, so it drains independently of the FSM.
    assign spawn_valid = spawn_pend_q;
    assign spawn_pc    = pc_q + XLEN'(4);
    assign illegal_op  = illegal_q;

    sb_alu #(.XLEN(XLEN)) u_alu (
        .aop    (get_aop(insn_q)),
        .a      (arg1_q),
        .b      (arg2_q),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_is_arith)    state_d = ST_EXEC;
                    else if (in_is_mem) state_d = ST_MEM_REQ;
                end
            end
            ST_EXEC:     state_d = ST_WB;
            ST_MEM_REQ:  if (dmem_req_ready) state_d = is_ld_q ? ST_MEM_WAIT : ST_IDLE;
            ST_MEM_WAIT: if (dmem_resp_valid) state_d = ST_WB;
            ST_WB:       state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready       = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_req_we    = 1'b0;
        dmem_req_addr  = '0;
        dmem_req_wdata = '0;
        rf_write_en    = 1'b0;
        rf_write_addr  = '0;
        rf_write_val   = '0;
        case (state_q)
            ST_IDLE: in_ready = !spawn_pend_q;
            ST_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_req_we    = is_st_q;
                dmem_req_addr  = arg1_q + imm_x;
                dmem_req_wdata = arg2_q;
            end
            ST_WB: begin
                rf_write_en   = (dest_q != '0);
                rf_write_addr = dest_q;
                rf_write_val  = result_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= '0;
            insn_q       <= '0;
            op_q         <= '0;
            arg1_q       <= '0;
            arg2_q       <= '0;
            result_q     <= '0;
            spawn_pend_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            illegal_q <= accept && !in_is_arith && !in_is_mem;
            if (accept) begin
                pc_q         <= in_pc;
                insn_q       <= in_insn;
                op_q         <= in_opcode;
                arg1_q       <= in_arg1;
                arg2_q       <= in_arg2;
                spawn_pend_q <= 1'b1;
            end else if (spawn_pend_q && spawn_ready) begin
                spawn_pend_q <= 1'b0;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_res;
            end else if ((state_q == ST_MEM_WAIT) && dmem_resp_valid) begin
                result_q <= dmem_resp_data;
            end
        end
    end

`ifdef SB_EXEC_PERF_CNT_EN
    logic [31:0] perf_arith_q, perf_mem_q, perf_illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_arith_q   <= '0;
            perf_mem_q     <= '0;
            perf_illegal_q <= '0;
        end else begin
            if ((state_q == ST_WB) && (op_q == OPW'(OP_ARITH))) perf_arith_q <= perf_arith_q + 32'd1;
            if (mem_fire)  perf_mem_q     <= perf_mem_q + 32'd1;
            if (illegal_q) perf_illegal_q <= perf_illegal_q + 32'd1;
        end
    end

    assign perf_arith   = perf_arith_q;
    assign perf_mem     = perf_mem_q;
    assign perf_illegal = perf_illegal_q;
`else
    logic unused_mem_fire;
    assign unused_mem_fire = mem_fire;
`endif

endmodule

// File: tb/tb_sb_exec_stage.sv
// tb/tb_sb_exec_stage.sv - scoreboard bench for sb_exec_stage
module tb_sb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_insn, in_arg1, in_arg2;
    logic [7:0]  in_opcode;
    logic        spawn_valid, spawn_ready;
    logic [31:0] spawn_pc;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_val;
    logic        illegal_op;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [4:0] addr; logic [31:0] val; } rf_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_exp_t;
    rf_exp_t     rf_q[$];
    req_exp_t    req_q[$];
    logic [31:0] spawn_q[$];
    rf_exp_t     rf_e;
    req_exp_t    req_e;
    logic [31:0] sp_e;

    always #5 clk = ~clk;

    sb_exec_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
        .in_opcode(in_opcode), .in_arg1(in_arg1), .in_arg2(in_arg2),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_pc(spawn_pc),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_val(rf_write_val),
        .illegal_op(illegal_op)
    );

    function automatic logic [31:0] mk_insn(input logic [4:0] rd, input logic [2:0] aop, input logic [11:0] imm);
        return {imm, 5'd0, aop, rd, 7'h13};
    endfunction

    function automatic logic [31:0] alu_model(input logic [2:0] aop, input logic [31:0] a, input logic [31:0] b);
        case (aop)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Scoreboard monitor: every handshake the DUT produces is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (rf_write_en) begin
                n_cmp++;
                if (rf_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rf_unexpected: got addr=%0d val=%h, required no write", rf_write_addr, rf_write_val);
                end else begin
                    rf_e = rf_q.pop_front();
                    if (rf_write_addr !== rf_e.addr || rf_write_val !== rf_e.val) begin
                        n_err++;
                        $display("FAIL rf_write: got addr=%0d val=%h, required addr=%0d val=%h",
                                 rf_write_addr, rf_write_val, rf_e.addr, rf_e.val);
                    end
                end
            end
            if (spawn_valid && spawn_ready) begin
                n_cmp++;
                if (spawn_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spawn_unexpected: got pc=%h, required no spawn", spawn_pc);
                end else begin
                    sp_e = spawn_q.pop_front();
                    if (spawn_pc !== sp_e) begin
                        n_err++;
                        $display("FAIL spawn_pc: got %h, required %h", spawn_pc, sp_e);
                    end
                end
            end
            if (dmem_req_valid && dmem_req_ready) begin
                n_cmp++;
                if (req_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_unexpected: got addr=%h we=%b, required no request", dmem_req_addr, dmem_req_we);
                end else begin
                    req_e = req_q.pop_front();
                    if (dmem_req_we !== req_e.we || dmem_req_addr !== req_e.addr || dmem_req_wdata !== req_e.wdata) begin
                        n_err++;
                        $display("FAIL dmem_req: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 dmem_req_we, dmem_req_addr, dmem_req_wdata, req_e.we, req_e.addr, req_e.wdata);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] insn, input logic [7:0] op,
                         input logic [31:0] a1, input logic [31:0] a2);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
        in_valid = 1'b1; in_pc = pc; in_insn = insn; in_opcode = op; in_arg1 = a1; in_arg2 = a2;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && !(in_ready === 1'b1 && rf_q.size() == 0); i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || spawn_valid !== 1'b0 || dmem_req_valid !== 1'b0 ||
            rf_write_en !== 1'b0 || illegal_op !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b spv=%b req=%b we=%b ill=%b, required 1 0 0 0 0",
                     in_ready, spawn_valid, dmem_req_valid, rf_write_en, illegal_op);
        end
        step();
    endtask

    task automatic test_arith_add();
        rf_q.push_back('{5'd3, 32'd12});
        spawn_q.push_back(32'h104);
        issue(32'h100, mk_insn(5'd3, 3'd0, 12'd0), 8'h01, 32'd5, 32'd7);
        @(negedge clk);
        n_cmp++;
        if (rf_write_en !== 1'b0) begin
            n_err++; $display("FAIL add_early_write: got %b at T+1, required 0", rf_write_en);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (rf_write_en !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL add_latency: got we=%b rdy=%b at T+2, required 1 0", rf_write_en, in_ready);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL add_next_accept: got in_ready=%b at T+3, required 1", in_ready);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] a, b;
        rf_q.push_back('{5'd5, 32'd0});
        spawn_q.push_back(32'h204);
        issue(32'h200, mk_insn(5'd5, 3'd0, 12'd0), 8'h01, 32'hFFFF_FFFF, 32'd1);
        rf_q.push_back('{5'd6, 32'd1});
        spawn_q.push_back(32'h208);
        issue(32'h204, mk_insn(5'd6, 3'd7, 12'd0), 8'h01, 32'hFFFF_FFFF, 32'd1);
        for (int k = 0; k < 16; k++) begin
            a = $urandom();
            b = (k < 8) ? $urandom() : {$urandom_range(1, 31)} ^ (32'h1 << 31);
            rf_q.push_back('{5'(10 + (k % 8)), alu_model(3'(k), a, b)});
            spawn_q.push_back(32'h300 + 32'(4 * k) + 32'd4);
            issue(32'h300 + 32'(4 * k), mk_insn(5'(10 + (k % 8)), 3'(k), 12'd0), 8'h01, a, b);
        end
        drain();
    endtask

    task automatic test_load();
        dmem_req_ready = 1'b0;
        req_q.push_back('{1'b0, 32'h0000_0FFC, 32'h0000_0011});
        spawn_q.push_back(32'h404);
        issue(32'h400, mk_insn(5'd7, 3'd2, 12'hFFC), 8'h02, 32'h1000, 32'h11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dmem_req_valid !== 1'b1 || dmem_req_addr !== 32'h0FFC || dmem_req_we !== 1'b0) begin
                n_err++;
                $display("FAIL ld_req_hold: cycle %0d got v=%b addr=%h we=%b, required 1 00000ffc 0",
                         i, dmem_req_valid, dmem_req_addr, dmem_req_we);
            end
            step();
        end
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dmem_req_valid !== 1'b0) begin
            n_err++; $display("FAIL ld_req_drop: got valid=%b after accept, required 0", dmem_req_valid);
        end
        step();
        step();
        rf_q.push_back('{5'd7, 32'hDEAD_BEEF});
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'hDEAD_BEEF;
        step();
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (rf_write_en !== 1'b1) begin
            n_err++; $display("FAIL ld_wb_timing: got rf_write_en=%b after resp, required 1", rf_write_en);
        end
        dmem_req_ready = 1'b1;
        drain();
    endtask

    task automatic test_store_x0();
        req_q.push_back('{1'b1, 32'h2008, 32'hAA});
        spawn_q.push_back(32'h504);
        issue(32'h500, mk_insn(5'd9, 3'd2, 12'd8), 8'h03, 32'h2000, 32'hAA);
        step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || rf_write_en !== 1'b0) begin
            n_err++; $display("FAIL st_idle: got rdy=%b we=%b after accept, required 1 0", in_ready, rf_write_en);
        end
        spawn_q.push_back(32'h604);
        issue(32'h600, mk_insn(5'd0, 3'd0, 12'd0), 8'h01, 32'd3, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_write_en !== 1'b0) begin
                n_err++; $display("FAIL x0_write: got rf_write_en=%b, required 0", rf_write_en);
            end
            step();
        end
    endtask

    task automatic test_spawn_bp_illegal();
        spawn_ready = 1'b0;
        rf_q.push_back('{5'd1, 32'd3});
        spawn_q.push_back(32'h704);
        issue(32'h700, mk_insn(5'd1, 3'd0, 12'd0), 8'h01, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || spawn_valid !== 1'b1 || spawn_pc !== 32'h704) begin
                n_err++;
                $display("FAIL spawn_hold: cycle %0d got rdy=%b spv=%b pc=%h, required 0 1 00000704",
                         i, in_ready, spawn_valid, spawn_pc);
            end
            step();
        end
        spawn_ready = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || spawn_valid !== 1'b0) begin
            n_err++; $display("FAIL spawn_release: got rdy=%b spv=%b, required 1 0", in_ready, spawn_valid);
        end
        spawn_q.push_back(32'h804);
        issue(32'h800, mk_insn(5'd2, 3'd0, 12'd0), 8'h04, 32'd1, 32'd1);
        @(negedge clk);
        n_cmp++;
        if (illegal_op !== 1'b1 || spawn_valid !== 1'b1) begin
            n_err++; $display("FAIL br_illegal: got ill=%b spv=%b, required 1 1", illegal_op, spawn_valid);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (illegal_op !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL br_pulse_end: got ill=%b rdy=%b, required 0 1", illegal_op, in_ready);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        spawn_ready = 1'b0;
        dmem_req_ready = 1'b1;
        req_q.push_back('{1'b0, 32'h40, 32'h0});
        issue(32'h900, mk_insn(5'd4, 3'd2, 12'd0), 8'h02, 32'h40, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || spawn_valid !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy=%b spv=%b req=%b, required 1 0 0", in_ready, spawn_valid, dmem_req_valid);
        end
        spawn_ready = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) dmem_resp_valid = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (rf_write_en !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL late_resp: got we=%b rdy=%b, required 0 1", rf_write_en, in_ready);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_insn = '0; in_opcode = '0;
        in_arg1 = '0; in_arg2 = '0; spawn_ready = 1'b1; dmem_req_ready = 1'b1;
        dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        test_reset();
        test_arith_add();
        test_alu_ops();
        test_load();
        test_store_x0();
        test_spawn_bp_illegal();
        test_reset_mid();
        repeat (5) step();
        n_cmp++;
        if (rf_q.size() != 0 || req_q.size() != 0 || spawn_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got rf=%0d req=%0d spawn=%0d pending, required 0 0 0",
                     rf_q.size(), req_q.size(), spawn_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
